// File: rtl/mem_stage_if.sv
// mem_stage_if: request/acknowledge data-memory port driven by mem_stage.
//
// Handshake: the master raises req together with addr/we/be/wdata and keeps
// all of them stable until the slave returns ack=1 for one cycle. rdata is
// valid in that ack cycle. ack outside an outstanding request is ignored.
//
// Signals:
//   req   master->slave  access request
//   we    master->slave  1 = write
//   addr  master->slave  word-aligned byte address
//   wdata master->slave  lane-replicated store data
//   be    master->slave  byte enables, little-endian lanes
//   ack   slave->master  access complete
//   rdata slave->master  read word, valid with ack
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
//
// Consumes the EX/MEM bundle, performs LB/LH/LW/SB/SH/SW through the dmem
// port, produces the MEM/WB bundle and passes the branch redirect through.
// While an aligned access is pending the upstream pipeline is stalled.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   EXMEM_*_i               EX/MEM pipeline register bundle
//   pc_src_o, pc_branch_o   combinational branch redirect
//   stall_o                 hold upstream stages (combinational)
//   misalign_o              registered one-cycle misaligned-access pulse
//   dmem                    data-memory port (mem_stage_if.master)
//   MEMWB_*_o               registered MEM/WB bundle
//   dbg_state_o             FSM state, 0 = IDLE, 1 = ACCESS
module mem_stage (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       EXMEM_pc_branch_i,
  input  logic [31:0]       EXMEM_alu_i,
  input  logic              EXMEM_alu_do_branch_i,
  input  logic [31:0]       EXMEM_b_i,
  input  logic [4:0]        EXMEM_reg_write_address_i,
  input  logic              EXMEM_ctrl_branch_i,
  input  logic [1:0]        EXMEM_ctrl_mem_read_i,
  input  logic [1:0]        EXMEM_ctrl_mem_write_i,
  input  logic              EXMEM_ctrl_reg_write_i,
  input  logic              EXMEM_ctrl_mem_to_reg_i,
  output logic              pc_src_o,
  output logic [31:0]       pc_branch_o,
  output logic              stall_o,
  output logic              misalign_o,
  mem_stage_if.master       dmem,
  output logic [31:0]       MEMWB_alu_o,
  output logic [31:0]       MEMWB_mem_data_o,
  output logic [4:0]        MEMWB_reg_write_address_o,
  output logic              MEMWB_ctrl_reg_write_o,
  output logic              MEMWB_ctrl_mem_to_reg_o,
  output logic              dbg_state_o
);

  typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_e;

  state_e      state_q;
  logic        req_q, we_q, misalign_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [31:0] mw_alu_q, mw_data_q;
  logic [4:0]  mw_rwa_q;
  logic        mw_rw_q, mw_m2r_q;

  logic        is_store, is_mem, misaligned, aligned_op;
  logic [1:0]  size;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // A store wins over a load when both fields are set.
    is_store   = |EXMEM_ctrl_mem_write_i;
    is_mem     = (|EXMEM_ctrl_mem_read_i) | is_store;
    size       = is_store ? EXMEM_ctrl_mem_write_i : EXMEM_ctrl_mem_read_i;
    misaligned = is_mem && ((size == 2'b10 && EXMEM_alu_i[0]) ||
                            (size == 2'b11 && EXMEM_alu_i[1:0] != 2'b00));
    aligned_op = is_mem && !misaligned;

    be_d    = 4'b0000;
    wdata_d = EXMEM_b_i;
    case (size)
      2'b01: begin
        be_d    = 4'b0001 << EXMEM_alu_i[1:0];
        wdata_d = {4{EXMEM_b_i[7:0]}};
      end
      2'b10: begin
        be_d    = EXMEM_alu_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{EXMEM_b_i[15:0]}};
      end
      2'b11:   be_d = 4'b1111;
      default: be_d = 4'b0000;
    endcase

    case (EXMEM_alu_i[1:0])
      2'b00:   byte_sel = dmem.rdata[7:0];
      2'b01:   byte_sel = dmem.rdata[15:8];
      2'b10:   byte_sel = dmem.rdata[23:16];
      default: byte_sel = dmem.rdata[31:24];
    endcase
    half_sel = EXMEM_alu_i[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];

    case (EXMEM_ctrl_mem_read_i)
      2'b01:   load_data = {{24{byte_sel[7]}}, byte_sel};
      2'b10:   load_data = {{16{half_sel[15]}}, half_sel};
      2'b11:   load_data = dmem.rdata;
      default: load_data = 32'h0;
    endcase
    if (is_store) load_data = 32'h0;
  end

  // IDLE stalls only for an aligned op; ACCESS releases in the ack cycle so
  // upstream advances on the same edge that retires the access.
  assign stall_o     = (state_q == S_IDLE) ? aligned_op : !dmem.ack;
  assign pc_src_o    = EXMEM_ctrl_branch_i & EXMEM_alu_do_branch_i;
  assign pc_branch_o = EXMEM_pc_branch_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      be_q       <= 4'b0000;
      misalign_q <= 1'b0;
      mw_alu_q   <= 32'h0;
      mw_data_q  <= 32'h0;
      mw_rwa_q   <= 5'd0;
      mw_rw_q    <= 1'b0;
      mw_m2r_q   <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (aligned_op) begin
            req_q    <= 1'b1;
            we_q     <= is_store;
            addr_q   <= {EXMEM_alu_i[31:2], 2'b00};
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            mw_rw_q  <= 1'b0;
            mw_m2r_q <= 1'b0;
            state_q  <= S_ACCESS;
          end else if (misaligned) begin
            // Dropped access: bubble into MEM/WB, no request issued.
            misalign_q <= 1'b1;
            mw_rw_q    <= 1'b0;
            mw_m2r_q   <= 1'b0;
          end else begin
            mw_alu_q  <= EXMEM_alu_i;
            mw_data_q <= 32'h0;
            mw_rwa_q  <= EXMEM_reg_write_address_i;
            mw_rw_q   <= EXMEM_ctrl_reg_write_i;
            mw_m2r_q  <= EXMEM_ctrl_mem_to_reg_i;
          end
        end
        S_ACCESS: begin
          if (dmem.ack) begin
            req_q     <= 1'b0;
            state_q   <= S_IDLE;
            mw_alu_q  <= EXMEM_alu_i;
            mw_data_q <= load_data;
            mw_rwa_q  <= EXMEM_reg_write_address_i;
            mw_rw_q   <= EXMEM_ctrl_reg_write_i;
            mw_m2r_q  <= EXMEM_ctrl_mem_to_reg_i;
          end else begin
            mw_rw_q  <= 1'b0;
            mw_m2r_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;
  assign dmem.be    = be_q;
  assign misalign_o = misalign_q;

  assign MEMWB_alu_o               = mw_alu_q;
  assign MEMWB_mem_data_o          = mw_data_q;
  assign MEMWB_reg_write_address_o = mw_rwa_q;
  assign MEMWB_ctrl_reg_write_o    = mw_rw_q;
  assign MEMWB_ctrl_mem_to_reg_o   = mw_m2r_q;
  assign dbg_state_o               = (state_q == S_ACCESS);

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage.
// The driver plays upstream pipeline and memory; each op is described at the
// transaction level and the expected per-cycle outputs are derived from the
// stage's rules. One negedge process compares every output each cycle.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] EXMEM_pc_branch_i, EXMEM_alu_i, EXMEM_b_i;
  logic        EXMEM_alu_do_branch_i, EXMEM_ctrl_branch_i;
  logic [4:0]  EXMEM_reg_write_address_i;
  logic [1:0]  EXMEM_ctrl_mem_read_i, EXMEM_ctrl_mem_write_i;
  logic        EXMEM_ctrl_reg_write_i, EXMEM_ctrl_mem_to_reg_i;
  logic        pc_src_o, stall_o, misalign_o, dbg_state_o;
  logic [31:0] pc_branch_o, MEMWB_alu_o, MEMWB_mem_data_o;
  logic [4:0]  MEMWB_reg_write_address_o;
  logic        MEMWB_ctrl_reg_write_o, MEMWB_ctrl_mem_to_reg_o;

  mem_stage_if dmem ();

  mem_stage dut (
    .clk_i                     (clk),
    .rst_i                     (rst_i),
    .EXMEM_pc_branch_i         (EXMEM_pc_branch_i),
    .EXMEM_alu_i               (EXMEM_alu_i),
    .EXMEM_alu_do_branch_i     (EXMEM_alu_do_branch_i),
    .EXMEM_b_i                 (EXMEM_b_i),
    .EXMEM_reg_write_address_i (EXMEM_reg_write_address_i),
    .EXMEM_ctrl_branch_i       (EXMEM_ctrl_branch_i),
    .EXMEM_ctrl_mem_read_i     (EXMEM_ctrl_mem_read_i),
    .EXMEM_ctrl_mem_write_i    (EXMEM_ctrl_mem_write_i),
    .EXMEM_ctrl_reg_write_i    (EXMEM_ctrl_reg_write_i),
    .EXMEM_ctrl_mem_to_reg_i   (EXMEM_ctrl_mem_to_reg_i),
    .pc_src_o                  (pc_src_o),
    .pc_branch_o               (pc_branch_o),
    .stall_o                   (stall_o),
    .misalign_o                (misalign_o),
    .dmem                      (dmem.master),
    .MEMWB_alu_o               (MEMWB_alu_o),
    .MEMWB_mem_data_o          (MEMWB_mem_data_o),
    .MEMWB_reg_write_address_o (MEMWB_reg_write_address_o),
    .MEMWB_ctrl_reg_write_o    (MEMWB_ctrl_reg_write_o),
    .MEMWB_ctrl_mem_to_reg_o   (MEMWB_ctrl_mem_to_reg_o),
    .dbg_state_o               (dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  bit chk_en = 1'b0;

  logic        exp_stall = 0, exp_pc_src = 0, exp_misalign = 0;
  logic        exp_req = 0, exp_state = 0, exp_we = 0;
  logic [31:0] exp_pc_branch = 0, exp_addr = 0, exp_wdata = 0;
  logic [3:0]  exp_be = 0;
  logic [31:0] exp_mw_alu = 0, exp_mw_data = 0;
  logic [4:0]  exp_mw_rwa = 0;
  logic        exp_mw_rw = 0, exp_mw_m2r = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] off);
    logic [31:0] s;
    s = w >> (8 * off);
    case (sz)
      2'b01:   load_ext = {{24{s[7]}}, s[7:0]};
      2'b10:   load_ext = {{16{s[15]}}, s[15:0]};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b01:   be_of = 4'b0001 << off;
      2'b10:   be_of = 4'b0011 << off;
      default: be_of = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_of(input logic [1:0] sz, input logic [31:0] b);
    case (sz)
      2'b01:   wdata_of = {4{b[7:0]}};
      2'b10:   wdata_of = {2{b[15:0]}};
      default: wdata_of = b;
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", stall_o, exp_stall);
      chk("pc_src", pc_src_o, exp_pc_src);
      chk("pc_branch", pc_branch_o, exp_pc_branch);
      chk("misalign", misalign_o, exp_misalign);
      chk("req", dmem.req, exp_req);
      chk("state", dbg_state_o, exp_state);
      chk("mw_alu", MEMWB_alu_o, exp_mw_alu);
      chk("mw_data", MEMWB_mem_data_o, exp_mw_data);
      chk("mw_rwa", MEMWB_reg_write_address_o, exp_mw_rwa);
      chk("mw_rw", MEMWB_ctrl_reg_write_o, exp_mw_rw);
      chk("mw_m2r", MEMWB_ctrl_mem_to_reg_o, exp_mw_m2r);
      if (exp_req) begin
        chk("addr", dmem.addr, exp_addr);
        chk("we", dmem.we, exp_we);
        chk("be", dmem.be, exp_be);
        chk("wdata", dmem.wdata, exp_wdata);
      end
      if (stall_o) stall_cnt++;
    end
  end

  // ---------------- driver ----------------
  // Called #1 after a rising edge; returns #1 after the edge that retires
  // the op. lat = number of request cycles without ack before the ack cycle.
  task automatic run_op(input logic [1:0] rd, input logic [1:0] wr,
                        input logic [31:0] alu, input logic [31:0] b,
                        input logic [4:0] rwa, input logic rw, input logic m2r,
                        input logic br, input logic dob, input logic [31:0] pcb,
                        input int lat, input logic [31:0] rfix, input bit use_fix);
    logic [1:0]  sz;
    logic        is_mem, is_wr, mis;
    logic [31:0] rdata;
    is_wr  = (wr != 2'b00);
    is_mem = is_wr || (rd != 2'b00);
    sz     = is_wr ? wr : rd;
    mis    = is_mem && ((sz == 2'b10 && alu[0]) || (sz == 2'b11 && alu[1:0] != 2'b00));
    rdata  = 32'h0;

    EXMEM_ctrl_mem_read_i     = rd;
    EXMEM_ctrl_mem_write_i    = wr;
    EXMEM_alu_i               = alu;
    EXMEM_b_i                 = b;
    EXMEM_reg_write_address_i = rwa;
    EXMEM_ctrl_reg_write_i    = rw;
    EXMEM_ctrl_mem_to_reg_i   = m2r;
    EXMEM_ctrl_branch_i       = br;
    EXMEM_alu_do_branch_i     = dob;
    EXMEM_pc_branch_i         = pcb;
    dmem.ack   = 1'($urandom_range(0, 1));   // ignored in IDLE
    dmem.rdata = $urandom;
    exp_pc_src    = br & dob;
    exp_pc_branch = pcb;
    exp_stall     = is_mem && !mis;
    exp_req       = 1'b0;
    exp_state     = 1'b0;
    @(posedge clk); #1;

    if (!is_mem) begin
      exp_mw_alu = alu; exp_mw_data = 32'h0; exp_mw_rwa = rwa;
      exp_mw_rw = rw; exp_mw_m2r = m2r; exp_misalign = 1'b0;
    end else if (mis) begin
      exp_mw_rw = 1'b0; exp_mw_m2r = 1'b0; exp_misalign = 1'b1;
      exp_stall = 1'b0;
    end else begin
      exp_mw_rw = 1'b0; exp_mw_m2r = 1'b0; exp_misalign = 1'b0;
      exp_req   = 1'b1; exp_state = 1'b1;
      exp_addr  = {alu[31:2], 2'b00};
      exp_we    = is_wr;
      exp_be    = be_of(sz, alu[1:0]);
      exp_wdata = wdata_of(sz, b);
      for (int i = 0; i <= lat; i++) begin
        dmem.ack   = (i == lat);
        dmem.rdata = (use_fix && i == lat) ? rfix : $urandom;
        rdata      = dmem.rdata;
        exp_stall  = (i != lat);
        @(posedge clk); #1;
      end
      exp_req = 1'b0; exp_state = 1'b0;
      exp_mw_alu  = alu;
      exp_mw_data = is_wr ? 32'h0 : load_ext(rdata, rd, alu[1:0]);
      exp_mw_rwa  = rwa; exp_mw_rw = rw; exp_mw_m2r = m2r;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    rst_i = 1'b1;
    EXMEM_pc_branch_i = 0; EXMEM_alu_i = 0; EXMEM_b_i = 0;
    EXMEM_alu_do_branch_i = 0; EXMEM_ctrl_branch_i = 0;
    EXMEM_reg_write_address_i = 0; EXMEM_ctrl_mem_read_i = 0;
    EXMEM_ctrl_mem_write_i = 0; EXMEM_ctrl_reg_write_i = 0;
    EXMEM_ctrl_mem_to_reg_i = 0;
    dmem.ack = 1'b0; dmem.rdata = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    chk_en = 1'b1;

    // reset state
    chk("rst_addr", dmem.addr, 32'h0);
    chk("rst_wdata", dmem.wdata, 32'h0);
    chk("rst_be", dmem.be, 32'h0);
    chk("rst_we", dmem.we, 32'h0);
    chk("rst_misalign", misalign_o, 32'h0);
    chk("rst_mw_alu", MEMWB_alu_o, 32'h0);
    rst_i = 1'b0;

    // model pins
    chk("model_lb", load_ext(32'h80FF_0000, 2'b01, 2'b11), 32'hFFFF_FF80);
    chk("model_lh", load_ext(32'h1234_8765, 2'b10, 2'b00), 32'hFFFF_8765);
    chk("model_lhu", load_ext(32'h7654_8765, 2'b10, 2'b10), 32'h0000_7654);
    chk("model_sh_be", be_of(2'b10, 2'b10), 32'hC);
    chk("model_sb_be", be_of(2'b01, 2'b01), 32'h2);
    chk("model_sh_wd", wdata_of(2'b10, 32'hABCD_BEEF), 32'hBEEF_BEEF);

    // ADD
    s0 = stall_cnt;
    run_op(2'b00, 2'b00, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0, 0);
    chk("add_alu", MEMWB_alu_o, 32'h1234);
    chk("add_rwa", MEMWB_reg_write_address_o, 32'd5);
    chk("add_stall_cycles", stall_cnt - s0, 32'd0);

    // LB with 3 wait cycles
    s0 = stall_cnt;
    run_op(2'b01, 2'b00, 32'h103, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 3,
           32'h80FF_0000, 1);
    chk("lb_data", MEMWB_mem_data_o, 32'hFFFF_FF80);
    chk("lb_stall_cycles", stall_cnt - s0, 32'd4);

    // SH, ack in first request cycle
    run_op(2'b00, 2'b10, 32'h102, 32'hABCD_BEEF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0, 0);
    chk("sh_mw_rw", MEMWB_ctrl_reg_write_o, 32'h0);

    // misaligned LW
    run_op(2'b11, 2'b00, 32'h6, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0, 0);
    chk("lw_mis_pulse", misalign_o, 32'h1);
    chk("lw_mis_req", dmem.req, 32'h0);
    chk("lw_mis_rw", MEMWB_ctrl_reg_write_o, 32'h0);

    // BEQ taken (inputs still applied after return)
    run_op(2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 0, 0, 0);
    chk("beq_pc_src", pc_src_o, 32'h1);
    chk("beq_pc_branch", pc_branch_o, 32'h40);

    // randomized ops
    for (int n = 0; n < 60; n++) begin
      logic [1:0] r, w;
      int k;
      k = $urandom_range(0, 3);
      r = (k == 1 || k == 3) ? 2'($urandom_range(1, 3)) : 2'b00;
      w = (k == 2 || k == 3) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_op(r, w, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), $urandom, $urandom_range(0, 3), 0, 0);
    end

    // reset during ACCESS, then a late ack
    EXMEM_ctrl_mem_read_i = 2'b11; EXMEM_ctrl_mem_write_i = 2'b00;
    EXMEM_alu_i = 32'h200; EXMEM_b_i = 32'h5A5A_0001;
    EXMEM_reg_write_address_i = 5'd7; EXMEM_ctrl_reg_write_i = 1'b1;
    EXMEM_ctrl_mem_to_reg_i = 1'b1; EXMEM_ctrl_branch_i = 1'b0;
    EXMEM_alu_do_branch_i = 1'b0; EXMEM_pc_branch_i = 32'h0;
    dmem.ack = 1'b0;
    exp_stall = 1'b1; exp_req = 1'b0; exp_state = 1'b0;
    exp_pc_src = 1'b0; exp_pc_branch = 32'h0;
    @(posedge clk); #1;
    exp_req = 1'b1; exp_state = 1'b1; exp_addr = 32'h200; exp_we = 1'b0;
    exp_be = be_of(2'b11, 2'b00); exp_wdata = wdata_of(2'b11, 32'h5A5A_0001);
    exp_mw_rw = 1'b0; exp_mw_m2r = 1'b0; exp_misalign = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    EXMEM_ctrl_mem_read_i = 2'b00; EXMEM_alu_i = 32'h0; EXMEM_b_i = 32'h0;
    EXMEM_reg_write_address_i = 5'd0; EXMEM_ctrl_reg_write_i = 1'b0;
    EXMEM_ctrl_mem_to_reg_i = 1'b0;
    dmem.ack = 1'b1; dmem.rdata = $urandom;
    exp_stall = 1'b0; exp_req = 1'b0; exp_state = 1'b0;
    exp_mw_alu = 0; exp_mw_data = 0; exp_mw_rwa = 0; exp_mw_rw = 0; exp_mw_m2r = 0;
    chk("rst_acc_req", dmem.req, 32'h0);
    chk("rst_acc_state", dbg_state_o, 32'h0);
    chk("rst_acc_mw_data", MEMWB_mem_data_o, 32'h0);
    chk("rst_acc_mw_rwa", MEMWB_reg_write_address_o, 32'h0);
    @(posedge clk); #1;
    dmem.ack = 1'b0;
    chk("late_ack_req", dmem.req, 32'h0);
    chk("late_ack_state", dbg_state_o, 32'h0);
    @(posedge clk); #1;
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
